// File: rtl/uart_pkg.sv
// Shared types and line levels for the UART frame transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } tx_state_t;

    localparam logic TX_IDLE_LEVEL  = 1'b1;
    localparam logic TX_START_LEVEL = 1'b0;

endpackage

// File: rtl/uart_tx_fifo.sv
// Word buffer for the UART transmitter: synchronous write, first-word-fall-through read.
// DEPTH must be a power of two so the pointers wrap naturally.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   br,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Storage array write port.
    // NOTE: the data array has no reset; only pointers and count define what is valid.
    always_ff @(posedge br) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push and pop leave the count unchanged.
    // NOTE: sequential state is only ever updated with non-blocking assignments.
    always_ff @(posedge br or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// UART frame transmitter: FIFO-buffered words serialised as start / data (LSB first) /
// optional parity / stop bits, each bit held CLKS_PER_BIT cycles of br.
// Optional line-break generation is built when UART_TX_BREAK_EN is defined.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        br,
    input  logic                        rst,
    input  logic [DATA_BITS-1:0]        din,
    input  logic                        din_valid,
    output logic                        din_ready,
    input  logic                        par_en,
    input  logic                        par_odd,
    input  logic                        retx,
`ifdef UART_TX_BREAK_EN
    input  logic                        break_req,
`endif
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = 4;
    localparam logic [CW-1:0] CYC_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    tx_state_t            state_q, state_d;
    logic [CW-1:0]        cyc_q, cyc_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_en_q, par_en_d;
    logic                 par_bit_q, par_bit_d;
    logic [DATA_BITS-1:0] last_q, last_d;
    logic                 last_valid_q, last_valid_d;
    logic                 tx_q, tx_d;
    logic                 busy_q;

    logic                 fifo_empty;
    logic                 fifo_full;
    logic [DATA_BITS-1:0] fifo_rdata;
    logic                 bit_end;
    logic                 sel_pt;
    logic                 do_break;
    logic                 do_retx;
    logic                 do_fifo;
    logic [DATA_BITS-1:0] load_word;

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .br      (br),
        .rst     (rst),
        .push_i  (din_valid),
        .wdata_i (din),
        .pop_i   (do_fifo),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign din_ready = !fifo_full;
    assign tx        = tx_q;
    assign busy      = busy_q;

    // Source selection happens in IDLE and on the last cycle of the last stop bit.
    assign bit_end = (cyc_q == CYC_LAST);
    assign sel_pt  = (state_q == IDLE) ||
                     ((state_q == STOP) && bit_end && (bit_q == STOP_LAST));
`ifdef UART_TX_BREAK_EN
    assign do_break = sel_pt && break_req;
`else
    assign do_break = 1'b0;
`endif
    assign do_retx   = sel_pt && !do_break && retx && last_valid_q;
    assign do_fifo   = sel_pt && !do_break && !do_retx && !fifo_empty;
    assign load_word = do_retx ? last_q : fifo_rdata;

    // Next-state, counters, shift register and per-frame config capture.
    // NOTE: every variable gets a default first so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        cyc_d        = bit_end ? '0 : cyc_q + CW'(1);
        bit_d        = bit_q;
        shift_d      = shift_q;
        par_en_d     = par_en_q;
        par_bit_d    = par_bit_q;
        last_d       = last_q;
        last_valid_d = last_valid_q;

        unique case (state_q)
            IDLE: begin
                cyc_d = '0;
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    bit_d   = '0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (bit_q == STOP_LAST) begin
                        state_d = IDLE;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            BREAK: begin
                cyc_d = '0;
`ifdef UART_TX_BREAK_EN
                if (!break_req) begin
                    state_d = STOP;
                    bit_d   = '0;
                end
`else
                state_d = IDLE;
`endif
            end
            default: begin
                state_d = IDLE;
                cyc_d   = '0;
                bit_d   = '0;
            end
        endcase

        if (do_break) begin
            state_d = BREAK;
            cyc_d   = '0;
            bit_d   = '0;
        end else if (do_retx || do_fifo) begin
            state_d      = START;
            cyc_d        = '0;
            bit_d        = '0;
            shift_d      = load_word;
            par_en_d     = par_en;
            par_bit_d    = (^load_word) ^ par_odd;
            last_d       = load_word;
            last_valid_d = 1'b1;
        end
    end

    // Line level for the current state; registered below so tx is glitch-free.
    always_comb begin
        tx_d = TX_IDLE_LEVEL;
        unique case (state_q)
            START:   tx_d = TX_START_LEVEL;
            DATA:    tx_d = shift_q[0];
            PARITY:  tx_d = par_bit_q;
            BREAK:   tx_d = TX_START_LEVEL;
            default: tx_d = TX_IDLE_LEVEL;
        endcase
    end

    // State register plus registered line outputs; reset aborts any frame at once.
    always_ff @(posedge br or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cyc_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            par_en_q     <= 1'b0;
            par_bit_q    <= 1'b0;
            last_q       <= '0;
            last_valid_q <= 1'b0;
            tx_q         <= TX_IDLE_LEVEL;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cyc_q        <= cyc_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            par_en_q     <= par_en_d;
            par_bit_q    <= par_bit_d;
            last_q       <= last_d;
            last_valid_q <= last_valid_d;
            tx_q         <= tx_d;
            busy_q       <= (state_q != IDLE);
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: two instances (1 and 2 stop bits) share stimulus;
// a frame-timeline model predicts tx/busy/fifo_count/din_ready every cycle.
module tb_uart_tx_frame;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int MAXC  = 8192;

    logic       br = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din = 8'h00;
    logic       din_valid = 1'b0;
    logic       par_en = 1'b0;
    logic       par_odd = 1'b0;
    logic       retx = 1'b0;
    logic [1:0] din_ready;
    logic [1:0] tx;
    logic [1:0] busy;
    logic [2:0] fifo_count [2];
`ifdef UART_TX_BREAK_EN
    logic       break_req = 1'b0;
`endif

    always #5 br = ~br;

    uart_tx_frame #(.DATA_BITS(8), .STOP_BITS(1), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut0 (
        .br(br), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready[0]),
        .par_en(par_en), .par_odd(par_odd), .retx(retx),
`ifdef UART_TX_BREAK_EN
        .break_req(break_req),
`endif
        .tx(tx[0]), .busy(busy[0]), .fifo_count(fifo_count[0])
    );

    uart_tx_frame #(.DATA_BITS(8), .STOP_BITS(2), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut1 (
        .br(br), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready[1]),
        .par_en(par_en), .par_odd(par_odd), .retx(retx),
`ifdef UART_TX_BREAK_EN
        .break_req(break_req),
`endif
        .tx(tx[1]), .busy(busy[1]), .fifo_count(fifo_count[1])
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model: per-cycle expected timeline ----------------
    int         cyc = 0;
    logic       exp_tx   [2][MAXC];
    logic       exp_busy [2][MAXC];
    int         exp_cnt  [2][MAXC];
    logic [7:0] mq [2][$];
    int         free_e [2];
    logic [7:0] last_w [2];
    logic       last_v [2];

    initial begin
        for (int d = 0; d < 2; d++) begin
            free_e[d] = 0;
            last_v[d] = 1'b0;
            last_w[d] = 8'h00;
            for (int i = 0; i < MAXC; i++) begin
                exp_tx[d][i]   = 1'b1;
                exp_busy[d][i] = 1'b0;
                exp_cnt[d][i]  = 0;
            end
        end
    end

    // Lay one frame onto the timeline: line bits occupy the cycles after load edge k.
    task automatic schedule(input int d, input int k, input logic [7:0] w, input logic pe, input logic po);
        logic bits[$];
        int   idx;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(w[i]);
        if (pe) bits.push_back((^w) ^ po);
        for (int s = 0; s < d + 1; s++) bits.push_back(1'b1);
        for (int j = 0; j < bits.size(); j++) begin
            for (int c = 0; c < CPB; c++) begin
                idx = k + 1 + j * CPB + c;
                if (idx < MAXC) begin
                    exp_tx[d][idx]   = bits[j];
                    exp_busy[d][idx] = 1'b1;
                end
            end
        end
        free_e[d] = k + bits.size() * CPB;
        last_w[d] = w;
        last_v[d] = 1'b1;
    endtask

    task automatic model_step(input int d);
        int         k;
        int         sz;
        logic [7:0] w;
        k = cyc;
        if (k >= MAXC) return;
        if (rst) begin
            mq[d].delete();
            last_v[d] = 1'b0;
            free_e[d] = k + 1;
            for (int i = k; i < k + 64 && i < MAXC; i++) begin
                exp_tx[d][i]   = 1'b1;
                exp_busy[d][i] = 1'b0;
            end
            exp_cnt[d][k] = 0;
        end else begin
            sz = mq[d].size();
            if (k >= free_e[d]) begin
                if (retx && last_v[d]) begin
                    schedule(d, k, last_w[d], par_en, par_odd);
                end else if (sz > 0) begin
                    w = mq[d].pop_front();
                    schedule(d, k, w, par_en, par_odd);
                end
            end
            if (din_valid && sz < DEPTH) mq[d].push_back(din);
            exp_cnt[d][k] = mq[d].size();
        end
    endtask

    always @(posedge br) begin
        cyc = cyc + 1;
        for (int d = 0; d < 2; d++) model_step(d);
    end

    // ---------------- compare process ----------------
    always @(negedge br) begin
        if (cyc > 0 && cyc < MAXC) begin
            for (int d = 0; d < 2; d++) begin
                if (rst) begin
                    check("rst_tx", 32'(tx[d]), 32'd1);
                    check("rst_busy", 32'(busy[d]), 32'd0);
                    check("rst_count", 32'(fifo_count[d]), 32'd0);
                    check("rst_ready", 32'(din_ready[d]), 32'd1);
                end else begin
                    check("tx", 32'(tx[d]), 32'(exp_tx[d][cyc]));
                    check("busy", 32'(busy[d]), 32'(exp_busy[d][cyc]));
                    check("fifo_count", 32'(fifo_count[d]), 32'(exp_cnt[d][cyc]));
                    check("din_ready", 32'(din_ready[d]), 32'(exp_cnt[d][cyc] < DEPTH));
                end
            end
        end
    end

    // ---------------- frame capture monitor (one sample per bit) ----------------
    logic [15:0] cur_bits [2];
    logic [15:0] done_bits [2];
    int          run [2];
    int          run_start [2];
    int          done_len [2];
    int          done_start [2];
    int          n_done [2];

    initial begin
        for (int d = 0; d < 2; d++) begin
            cur_bits[d] = '0; done_bits[d] = '0; run[d] = 0; run_start[d] = 0;
            done_len[d] = 0; done_start[d] = 0; n_done[d] = 0;
        end
    end

    always @(negedge br) begin
        for (int d = 0; d < 2; d++) begin
            if (busy[d] === 1'b1) begin
                if (run[d] == 0) begin
                    cur_bits[d]  = '0;
                    run_start[d] = cyc;
                end
                if (run[d] % CPB == 0 && run[d] / CPB < 16) cur_bits[d][run[d] / CPB] = tx[d];
                run[d]++;
            end else if (run[d] > 0) begin
                done_bits[d]  = cur_bits[d];
                done_len[d]   = run[d];
                done_start[d] = run_start[d];
                n_done[d]++;
                run[d] = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    int push_edge = 0;

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge br);
            #2;
        end
    endtask

    task automatic push(input logic [7:0] w);
        din       = w;
        din_valid = 1'b1;
        step();
        push_edge = cyc;
        din_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int quiet;
        int t;
        quiet = 0;
        t = 0;
        while (quiet < 3 && t < 3000) begin
            step();
            t++;
            if (busy == 2'b00 && fifo_count[0] == 3'd0 && fifo_count[1] == 3'd0) quiet++;
            else quiet = 0;
        end
        check({name, "_idle_timeout"}, 32'(t < 3000), 32'd1);
    endtask

    initial begin
        step(3);
        rst = 1'b0;
        step(2);

        // retx before any word has been sent: no frame
        retx = 1'b1;
        step();
        retx = 1'b0;
        step(10);
        check("retx_before_send", 32'(n_done[0] + n_done[1] + run[0] + run[1]), 32'd0);

        // 0xA5, even parity
        par_en  = 1'b1;
        par_odd = 1'b0;
        push(8'hA5);
        wait_idle("a5");
        check("a5_bits_s1", 32'(done_bits[0]), 32'h54A);
        check("a5_len_s1", 32'(done_len[0]), 32'd44);
        check("a5_latency", 32'(done_start[0] - push_edge), 32'd2);
        check("a5_bits_s2", 32'(done_bits[1]), 32'hD4A);
        check("a5_len_s2", 32'(done_len[1]), 32'd48);

        // 0x00, odd parity
        par_odd = 1'b1;
        push(8'h00);
        wait_idle("z0");
        check("z0_bits_s2", 32'(done_bits[1]), 32'hE00);
        check("z0_len_s2", 32'(done_len[1]), 32'd48);
        check("z0_bits_s1", 32'(done_bits[0]), 32'h600);

        // five pushes while the first frame runs: FIFO fills, frames run back-to-back
        par_odd   = 1'b0;
        din_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            din = 8'(8'h11 * (i + 1));
            step();
        end
        din_valid = 1'b0;
        check("fill_count", 32'(fifo_count[0]), 32'd4);
        check("fill_ready", 32'(din_ready[0]), 32'd0);
        wait_idle("b2b");
        check("b2b_run_s1", 32'(done_len[0]), 32'd220);
        check("b2b_run_s2", 32'(done_len[1]), 32'd240);

        // send 0x3C then resend it with retx
        push(8'h3C);
        wait_idle("x3c");
        check("x3c_bits", 32'(done_bits[0]), 32'h478);
        begin
            int n0;
            n0 = n_done[0];
            retx = 1'b1;
            step();
            retx = 1'b0;
            check("retx_count", 32'(fifo_count[0]), 32'd0);
            wait_idle("retx");
            check("retx_frames", 32'(n_done[0]), 32'(n0 + 1));
        end
        check("retx_bits_s1", 32'(done_bits[0]), 32'h478);
        check("retx_bits_s2", 32'(done_bits[1]), 32'hC78);

        // reset in the middle of the data bits
        push(8'h00);
        step(8);
        check("mid_data_tx", 32'(tx[0]), 32'd0);
        rst = 1'b1;
        #1;
        check("abort_tx", 32'(tx[0]), 32'd1);
        check("abort_busy", 32'(busy[0]), 32'd0);
        check("abort_count", 32'(fifo_count[0]), 32'd0);
        step(2);
        rst = 1'b0;
        push(8'h5A);
        wait_idle("after_rst");
        check("after_rst_bits_s1", 32'(done_bits[0]), 32'h4B4);
        check("after_rst_bits_s2", 32'(done_bits[1]), 32'hCB4);
        check("after_rst_len_s1", 32'(done_len[0]), 32'd44);

        // randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            din_valid = ($urandom_range(0, 9) < 3);
            din       = 8'($urandom);
            par_en    = 1'($urandom);
            par_odd   = 1'($urandom);
            retx      = ($urandom_range(0, 19) == 0);
            step();
        end
        din_valid = 1'b0;
        retx      = 1'b0;
        wait_idle("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
